outer_prod_mac_array: RTL and testbench

//  Parametrised, pipelined outer-product multiply-accumulate array; next generation of the combinational 4x4 product array.

---
 rtl/mac_arr_pkg.sv | 24 ++
 rtl/mac_arr_cell.sv | 69 ++++++
 rtl/outer_prod_mac_array.sv | 125 ++++++++++++
 tb/tb_outer_prod_mac_array.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_arr_pkg.sv
// Purpose: shared defaults and the accumulator wrap detector for the outer-product MAC array.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package mac_arr_pkg;

    localparam int N_W_DEF    = 4;
    localparam int N_I_DEF    = 4;
    localparam int DW_DEF     = 16;
    localparam int ACC_W_DEF  = 40;
    localparam int SIGNED_DEF = 0;
    localparam int CNT_W_DEF  = 16;

    // a, b, sum are the MSBs of the addend, the product and the result.
    // Signed: wrap when both operands share a sign the result does not have.
    // Unsigned: wrap is the carry out of the MSB, rebuilt from the three MSBs.
    function automatic logic acc_ovf(input logic a, input logic b, input logic sum,
                                     input logic signed_mode);
        if (signed_mode)
            return (a == b) && (sum != a);
        else
            return (a & b) | ((a ^ b) & ~sum);
    endfunction

endpackage

// File: rtl/mac_arr_cell.sv
// Purpose: one array cell - registered extended product, tile accumulator, sticky wrap flag.
// Latency: product registered on accept; o_sum/o_ovf are combinational from the registers.
// Backpressure: none locally; the top gates i_load/i_acc_en.
// Ports: i_load captures wt*ip; i_acc_en folds the product in (i_first restarts the tile);
//        i_last clears the wrap flag for the next tile; i_flush clears accumulator and flag;
//        o_sum is the running sum including the current product, o_ovf the tile wrap flag.
module mac_cell
    import mac_arr_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SIGNED = SIGNED_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [DW-1:0]    i_wt,
    input  logic [DW-1:0]    i_ip,
    input  logic             i_acc_en,
    input  logic             i_first,
    input  logic             i_last,
    input  logic             i_flush,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);

    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W-1:0] w_base;
    logic             w_ovf_now;
    logic [ACC_W-1:0] r_prod;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;

    // Operands are widened to 2*DW before multiplying so the product is exact.
    if (SIGNED != 0) begin : g_signed
        logic signed [2*DW-1:0] w_prod;
        assign w_prod     = $signed({{DW{i_wt[DW-1]}}, i_wt}) * $signed({{DW{i_ip[DW-1]}}, i_ip});
        assign w_prod_ext = ACC_W'(w_prod);
    end else begin : g_unsigned
        logic [2*DW-1:0] w_prod;
        assign w_prod     = {{DW{1'b0}}, i_wt} * {{DW{1'b0}}, i_ip};
        assign w_prod_ext = ACC_W'(w_prod);
    end

    // The first beat of a tile starts from zero instead of the stale sum.
    assign w_base    = i_first ? '0 : r_acc;
    assign o_sum     = w_base + r_prod;
    assign w_ovf_now = acc_ovf(w_base[ACC_W-1], r_prod[ACC_W-1], o_sum[ACC_W-1], SIGNED != 0);
    assign o_ovf     = w_ovf_now | (r_ovf & ~i_first);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (i_load)
                r_prod <= w_prod_ext;
            if (i_flush) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (i_acc_en) begin
                r_acc <= o_sum;
                r_ovf <= o_ovf & ~i_last;
            end
        end
    end

endmodule

// File: rtl/outer_prod_mac_array.sv
// Purpose: pipelined N_W x N_I outer-product MAC array, tiles delimited by in_last, results buffered.
// Latency: last beat accepted at cycle t -> out_valid at t+2; 1 beat/cycle sustained.
// Backpressure: in_ready drops only when a finished tile waits in S1 behind an unconsumed result, or on flush.
// Ports: in_valid/in_ready/in_last + wts/ips carry beats; out_valid/out_ready hand over
//        out_acc (cell N_I*i+j = sum wts[i]*ips[j]), out_beats (saturating) and out_ovf.
module outer_prod_mac_array
    import mac_arr_pkg::*;
#(
    parameter int N_W    = N_W_DEF,
    parameter int N_I    = N_I_DEF,
    parameter int DW     = DW_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SIGNED = SIGNED_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [N_W*DW-1:0]        wts,
    input  logic [N_I*DW-1:0]        ips,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_W*N_I*ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0]         out_beats,
    output logic                     out_ovf
);

    localparam int NC = N_W * N_I;

    logic                       w_stall;
    logic                       w_accept;
    logic                       w_acc_en;
    logic                       w_load;
    logic [CNT_W-1:0]           w_cnt_next;
    logic [NC-1:0][ACC_W-1:0]   w_sum;
    logic [NC-1:0]              w_ovf;

    logic                       r_s1_valid;
    logic                       r_s1_last;
    logic                       r_first;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_out_valid;
    logic [NC-1:0][ACC_W-1:0]   r_out_acc;
    logic [CNT_W-1:0]           r_out_beats;
    logic                       r_out_ovf;

    // Only a tile-closing beat needs the output buffer, so only it can stall.
    assign w_stall    = r_s1_valid && r_s1_last && r_out_valid && !out_ready;
    assign in_ready   = !w_stall && !flush;
    assign w_accept   = in_valid && in_ready;
    assign w_acc_en   = r_s1_valid && !w_stall && !flush;
    assign w_load     = w_acc_en && r_s1_last;
    assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    for (genvar gi = 0; gi < N_W; gi++) begin : g_row
        for (genvar gj = 0; gj < N_I; gj++) begin : g_col
            mac_cell #(
                .DW     (DW),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_load   (w_accept),
                .i_wt     (wts[gi*DW +: DW]),
                .i_ip     (ips[gj*DW +: DW]),
                .i_acc_en (w_acc_en),
                .i_first  (r_first),
                .i_last   (r_s1_last),
                .i_flush  (flush),
                .o_sum    (w_sum[gi*N_I + gj]),
                .o_ovf    (w_ovf[gi*N_I + gj])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_first     <= 1'b1;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_beats <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
                r_s1_last  <= 1'b0;
            end else if (!w_stall) begin
                r_s1_valid <= w_accept;
                if (w_accept)
                    r_s1_last <= in_last;
            end

            if (flush) begin
                r_cnt   <= '0;
                r_first <= 1'b1;
            end else if (w_acc_en) begin
                r_cnt   <= r_s1_last ? '0 : w_cnt_next;
                r_first <= r_s1_last;
            end

            // A new tile load wins over the consumer draining the buffer.
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_acc   <= w_sum;
                r_out_beats <= w_cnt_next;
                r_out_ovf   <= |w_ovf;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_beats = r_out_beats;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_outer_prod_mac_array.sv
module tb_outer_prod_mac_array;

    typedef struct {
        logic [15:0][39:0] acc;
        int                beats;
        bit                ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush     [3];
    logic        in_valid  [3];
    logic        in_last   [3];
    logic        in_ready  [3];
    logic        out_ready [3];
    logic        out_valid [3];
    logic        out_ovf   [3];
    logic [63:0] wts       [3];
    logic [63:0] ips       [3];
    logic [15:0] out_beats [3];
    logic [639:0] oacc40   [2];
    logic [511:0] oacc32;

    int   total = 0;
    int   bad   = 0;
    exp_t q[3][$];

    always #5 clk = ~clk;

    // DUT 0: defaults (unsigned, 40-bit accumulators)
    outer_prod_mac_array u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_last(in_last[0]),
        .wts(wts[0]), .ips(ips[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_acc(oacc40[0]), .out_beats(out_beats[0]), .out_ovf(out_ovf[0])
    );

    // DUT 1: signed
    outer_prod_mac_array #(.SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_last(in_last[1]),
        .wts(wts[1]), .ips(ips[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_acc(oacc40[1]), .out_beats(out_beats[1]), .out_ovf(out_ovf[1])
    );

    // DUT 2: unsigned, 32-bit accumulators (wraps easily)
    outer_prod_mac_array #(.ACC_W(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .flush(flush[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_last(in_last[2]),
        .wts(wts[2]), .ips(ips[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_acc(oacc32), .out_beats(out_beats[2]), .out_ovf(out_ovf[2])
    );

    function automatic logic [39:0] get_cell(input int d, input int k);
        if (d < 2) return oacc40[d][k*40 +: 40];
        return {8'b0, oacc32[k*32 +: 32]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Same lane data on every beat of the tile: cell = nb * wts[i]*ips[j] mod 2^accw.
    function automatic exp_t mk(input logic [63:0] w, input logic [63:0] ip, input int nb,
                                input int accw, input bit sgn);
        exp_t   e;
        longint a, b, t, lim;
        e.ovf   = 1'b0;
        e.beats = nb;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a = sgn ? longint'($signed(w[i*16 +: 16]))  : longint'(w[i*16 +: 16]);
                b = sgn ? longint'($signed(ip[j*16 +: 16])) : longint'(ip[j*16 +: 16]);
                t = a * b * longint'(nb);
                if (sgn) begin
                    lim = longint'(1) <<< (accw - 1);
                    if (t >= lim || t < -lim) e.ovf = 1'b1;
                end else if (t >= (longint'(1) << accw)) begin
                    e.ovf = 1'b1;
                end
                e.acc[i*4 + j] = 40'(t & ((longint'(1) << accw) - 1));
            end
        end
        return e;
    endfunction

    function automatic exp_t fill(input logic [39:0] v, input int nb, input bit ovf);
        exp_t e;
        for (int k = 0; k < 16; k++) e.acc[k] = v;
        e.beats = nb;
        e.ovf   = ovf;
        return e;
    endfunction

    // Drives nb beats back to back; returns just after the edge accepting the final beat.
    task automatic send(input int d, input logic [63:0] w, input logic [63:0] ip,
                        input int nb, input bit last);
        for (int b = 0; b < nb; b++) begin
            int n = 0;
            @(negedge clk);
            in_valid[d] = 1'b1;
            in_last[d]  = last && (b == nb - 1);
            wts[d]      = w;
            ips[d]      = ip;
            #1;
            while (!in_ready[d] && n < 200) begin
                n++;
                @(negedge clk);
                #1;
            end
            if (n >= 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout dut%0d: in_ready stuck at 0 for %0d cycles, required 1", d, n);
                return;
            end
            @(posedge clk);
        end
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
    endtask

    // Monitor: pops an expectation whenever a DUT hands over a result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            for (int d = 0; d < 3; d++) begin
                if (rst_n && out_valid[d] && out_ready[d]) begin
                    if (q[d].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result dut%0d: got out_valid=1 beats=%0d, required no result", d, out_beats[d]);
                    end else begin
                        e = q[d].pop_front();
                        for (int k = 0; k < 16; k++)
                            check($sformatf("dut%0d_acc[%0d]", d, k), 64'(get_cell(d, k)), 64'(e.acc[k]));
                        check($sformatf("dut%0d_beats", d), 64'(out_beats[d]), 64'(e.beats));
                        check($sformatf("dut%0d_ovf", d), 64'(out_ovf[d]), 64'(e.ovf));
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            flush[d] = 1'b0; in_valid[d] = 1'b0; in_last[d] = 1'b0;
            out_ready[d] = 1'b1; wts[d] = '0; ips[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid[0]), 64'd0);
        check("rst_out_beats", 64'(out_beats[0]), 64'd0);
        check("rst_out_ovf",   64'(out_ovf[0]), 64'd0);
        check("rst_acc0",      64'(get_cell(0, 0)), 64'd0);
        check("rst_in_ready",  64'(in_ready[0]), 64'd1);

        // Single-beat tile, distinct lanes; latency check around it.
        q[0].push_back(mk(64'h0004_0003_0002_0001, 64'h0001_0002_0003_0004, 1, 40, 1'b0));
        send(0, 64'h0004_0003_0002_0001, 64'h0001_0002_0003_0004, 1, 1'b1);
        idle(0);
        #1;
        check("lat_t1_out_valid", 64'(out_valid[0]), 64'd0);
        @(negedge clk);
        #1;
        check("lat_t2_out_valid", 64'(out_valid[0]), 64'd1);

        // 3-beat tile of 2*5, then back-to-back 1-beat tile of ones.
        q[0].push_back(fill(40'd30, 3, 1'b0));
        q[0].push_back(fill(40'd1, 1, 1'b0));
        send(0, {4{16'd2}}, {4{16'd5}}, 3, 1'b1);
        send(0, {4{16'd1}}, {4{16'd1}}, 1, 1'b1);
        idle(0);
        drain();

        // Backpressure: two 2-beat tiles while the consumer stalls.
        @(negedge clk);
        out_ready[0] = 1'b0;
        q[0].push_back(mk({4{16'd1}}, 64'h0004_0003_0002_0001, 2, 40, 1'b0));
        q[0].push_back(mk({4{16'd2}}, 64'h0001_0001_0003_0003, 2, 40, 1'b0));
        send(0, {4{16'd1}}, 64'h0004_0003_0002_0001, 2, 1'b1);
        send(0, {4{16'd2}}, 64'h0001_0001_0003_0003, 2, 1'b1);
        idle(0);
        #1;
        check("bp_in_ready_low", 64'(in_ready[0]), 64'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("bp_hold_valid_%0d", c), 64'(out_valid[0]), 64'd1);
            check($sformatf("bp_hold_beats_%0d", c), 64'(out_beats[0]), 64'd2);
            check($sformatf("bp_hold_acc5_%0d", c), 64'(get_cell(0, 5)), 64'd4);
        end
        @(negedge clk);
        out_ready[0] = 1'b1;
        @(negedge clk);
        #1;
        check("bp_in_ready_back", 64'(in_ready[0]), 64'd1);
        drain();

        // Flush after 2 of 4 beats; a beat offered during flush must be refused.
        send(0, {4{16'd7}}, {4{16'd3}}, 2, 1'b0);
        @(negedge clk);
        flush[0] = 1'b1; in_valid[0] = 1'b1; in_last[0] = 1'b1;
        wts[0] = {4{16'd9}}; ips[0] = {4{16'd9}};
        #1;
        check("flush_in_ready", 64'(in_ready[0]), 64'd0);
        @(negedge clk);
        flush[0] = 1'b0; in_valid[0] = 1'b0; in_last[0] = 1'b0;
        q[0].push_back(fill(40'd1, 1, 1'b0));
        send(0, {4{16'd1}}, {4{16'd1}}, 1, 1'b1);
        idle(0);
        drain();

        // Signed: -3 * 7 over 2 beats = -42 in every cell.
        q[1].push_back(fill(40'hFF_FFFF_FFD6, 2, 1'b0));
        send(1, {4{16'hFFFD}}, {4{16'd7}}, 2, 1'b1);
        idle(1);
        // Unsigned 32-bit: 2 * 0xFFFE0001 wraps to 0xFFFC0002.
        q[2].push_back(fill(40'h00_FFFC_0002, 2, 1'b1));
        send(2, {4{16'hFFFF}}, {4{16'hFFFF}}, 2, 1'b1);
        idle(2);
        drain();

        // Reset mid-tile with a result still pending: everything is lost.
        @(negedge clk);
        out_ready[0] = 1'b0;
        send(0, {4{16'd3}}, {4{16'd3}}, 1, 1'b1);
        send(0, {4{16'd5}}, {4{16'd5}}, 2, 1'b0);
        @(negedge clk);
        in_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
        check("midrst_out_beats", 64'(out_beats[0]), 64'd0);
        check("midrst_out_ovf",   64'(out_ovf[0]), 64'd0);
        check("midrst_acc0",      64'(get_cell(0, 0)), 64'd0);
        check("midrst_acc15",     64'(get_cell(0, 15)), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready[0] = 1'b1;
        q[0].push_back(mk(64'h0001_0002_0003_0004, 64'h0002_0002_0001_0001, 1, 40, 1'b0));
        send(0, 64'h0001_0002_0003_0004, 64'h0002_0002_0001_0001, 1, 1'b1);
        idle(0);
        drain();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
